// File: rtl/aes_decrypt_iter_if.sv
// Bus bundle for the iterative AES-128 decryptor: block, key, result and
// the start/done handshake. Shape matches the encryptor's bundle.
interface aes_decrypt_iter_if;
  logic [127:0] data;
  logic [127:0] key;
  logic [127:0] out;
  logic         start;
  logic         done;

  modport master (output data, key, start, input out, done);
  modport slave  (input data, key, start, output out, done);
endinterface

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 inverse cipher, one round per clock. The last round key
// is produced on chip by a forward key expansion, then earlier round keys
// are regenerated on the fly with the inverse key schedule.
// Byte k of every 128-bit word is bits [8k+7:8k] = row k/4, column k%4.

package aes_decrypt_iter_pkg;
  typedef logic [15:0][7:0] blk_t;

  // GF(2^8) multiply, reduction polynomial 0x11B
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    logic [7:0] e;
    r  = 8'h01;
    sq = a;
    e  = 8'hFE;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gf_mul(r, sq);
      sq = gf_mul(sq, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1B;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction
endpackage

// Forward S-box: inverse in GF(2^8) followed by the affine map
module sbox
  import aes_decrypt_iter_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] v;
  assign v = gf_inv(a);
  assign y = v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
endmodule

// Inverse S-box: inverse affine map followed by the GF(2^8) inverse
module inv_sbox
  import aes_decrypt_iter_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] u;
  assign u = rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
  assign y = gf_inv(u);
endmodule

module aes_decrypt_iter
  import aes_decrypt_iter_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic               clk,
  input  logic               rst,
  aes_decrypt_iter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEXP,
    S_INIT,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

  state_t       st, st_nx;
  blk_t         blk_r;
  blk_t         key_r;
  logic [127:0] out_r;
  logic         done_r;
  logic [3:0]   cnt;

  // ---------------------------------------------------------------------
  // Key schedule: four shared forward S-boxes serve both directions
  // ---------------------------------------------------------------------
  logic [3:0][7:0] tw;      // w3 (forward) or w3^w2 (inverse), by row
  logic [3:0][7:0] sb_in;
  logic [3:0][7:0] sb_out;
  logic [3:0]      rc_idx;
  blk_t            key_fwd;
  blk_t            key_inv;

  // Select the word fed to RotWord/SubWord for the active direction
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      tw[r] = (st == S_KEXP) ? key_r[4*r+3] : (key_r[4*r+3] ^ key_r[4*r+2]);
    end
    for (int r = 0; r < 4; r++) begin
      sb_in[r] = tw[(r+1)%4];
    end
  end

  genvar g;
  for (g = 0; g < 4; g++) begin : g_ksb
    sbox u_sb (.a(sb_in[g]), .y(sb_out[g]));
  end

  assign rc_idx = (st == S_INIT) ? 4'(NR) : cnt;

  // Next round key forward (rk_i -> rk_i+1) and backward (rk_i -> rk_i-1)
  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    logic [3:0][7:0] t;
    key_fwd = '0;
    key_inv = '0;
    t       = sb_out;
    t[0]    = sb_out[0] ^ rcon(rc_idx);
    for (int r = 0; r < 4; r++) begin
      key_fwd[4*r+0] = key_r[4*r+0] ^ t[r];
      key_fwd[4*r+1] = key_r[4*r+1] ^ key_fwd[4*r+0];
      key_fwd[4*r+2] = key_r[4*r+2] ^ key_fwd[4*r+1];
      key_fwd[4*r+3] = key_r[4*r+3] ^ key_fwd[4*r+2];
      key_inv[4*r+3] = key_r[4*r+3] ^ key_r[4*r+2];
      key_inv[4*r+2] = key_r[4*r+2] ^ key_r[4*r+1];
      key_inv[4*r+1] = key_r[4*r+1] ^ key_r[4*r+0];
      key_inv[4*r+0] = key_r[4*r+0] ^ t[r];
    end
  end

  // ---------------------------------------------------------------------
  // State datapath: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns
  // ---------------------------------------------------------------------
  blk_t sr;
  blk_t isb_o;
  blk_t ark;
  blk_t imc;

  // Row r rotates right by r columns
  always_comb begin
    sr = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sr[4*r+c] = blk_r[4*r+((c-r+4)%4)];
      end
    end
  end

  for (g = 0; g < 16; g++) begin : g_isb
    inv_sbox u_isb (.a(sr[g]), .y(isb_o[g]));
  end

  assign ark = isb_o ^ key_r;

  // Per-column circulant 0E 0B 0D 09
  always_comb begin
    logic [3:0][7:0] a;
    imc = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = ark[4*r+c];
      for (int r = 0; r < 4; r++) begin
        imc[4*r+c] = gf_mul(8'h0E, a[r])       ^ gf_mul(8'h0B, a[(r+1)%4]) ^
                     gf_mul(8'h0D, a[(r+2)%4]) ^ gf_mul(8'h09, a[(r+3)%4]);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------

  // State register
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= S_IDLE;
    else      st <= st_nx;
  end

  // Next-state logic; start is only honoured in IDLE and DONE
  always_comb begin
    st_nx = st;
    case (st)
      S_IDLE, S_DONE: if (bus.start) st_nx = S_KEXP;
      S_KEXP:         if (cnt == 4'(NR)) st_nx = S_INIT;
      S_INIT:         st_nx = S_ROUND;
      S_ROUND:        if (cnt == 4'd1) st_nx = S_FINAL;
      S_FINAL:        st_nx = S_DONE;
      default:        st_nx = S_IDLE;
    endcase
  end

  // Datapath, key and counter registers, advanced according to the state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blk_r  <= '0;
      key_r  <= '0;
      out_r  <= '0;
      done_r <= 1'b0;
      cnt    <= '0;
    end else begin
      case (st)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            blk_r  <= bus.data;
            key_r  <= bus.key;
            cnt    <= 4'd1;
            done_r <= 1'b0;
          end
        end
        S_KEXP: begin
          key_r <= key_fwd;
          cnt   <= cnt + 4'd1;
        end
        S_INIT: begin
          blk_r <= blk_r ^ key_r;
          key_r <= key_inv;
          cnt   <= 4'(NR - 1);
        end
        S_ROUND: begin
          blk_r <= imc;
          key_r <= key_inv;
          cnt   <= cnt - 4'd1;
        end
        S_FINAL: begin
          out_r  <= ark;
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.out  = out_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Bench for aes_decrypt_iter: textbook AES-128 model (full key expansion,
// table S-boxes), a cycle predictor for start/done timing, and directed
// scenarios for latency, busy handling, restart from DONE, reset abort and
// back-to-back operation.
module tb_aes_decrypt_iter;

  localparam logic [127:0] FIPS_K  = 128'h3C88A616_4F15D215_CFF7AE7E_09AB282B;
  localparam logic [127:0] FIPS_CT = 128'h3297FB1D_0B850984_6A11DC25_19DC0239;
  localparam logic [127:0] FIPS_PT = 128'h34A28DA8_079830F6_37315A43_E0318832;
  localparam logic [127:0] ZERO_CT = 128'h2E593BD4_2BFA2C4B_344C8AE9_CA88EF66;

  logic clk = 1'b0;
  logic rst = 1'b0;

  aes_decrypt_iter_if bus ();

  aes_decrypt_iter #(.NR(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] r8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int r, input int c);
    return s[8*(4*r+c) +: 8];
  endfunction

  // Round key rnd in native layout, from a full 44-word expansion
  function automatic logic [127:0] rkey(input logic [127:0] k, input int rnd);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = {gb(k, 0, i), gb(k, 1, i), gb(k, 2, i), gb(k, 3, i)};
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[8*(4*r+c) +: 8] = w[4*rnd+c][8*(3-r) +: 8];
    return res;
  endfunction

  function automatic logic [127:0] sub_b(input logic [127:0] s, input bit inv);
    logic [127:0] n;
    for (int k = 0; k < 16; k++) n[8*k +: 8] = inv ? isb[s[8*k +: 8]] : sb[s[8*k +: 8]];
    return n;
  endfunction

  function automatic logic [127:0] shift_r(input logic [127:0] s, input bit inv);
    logic [127:0] n;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        n[8*(4*r+c) +: 8] = inv ? gb(s, r, (c - r + 4) % 4) : gb(s, r, (c + r) % 4);
    return n;
  endfunction

  function automatic logic [127:0] mix_c(input logic [127:0] s, input bit inv);
    logic [127:0] n;
    logic [7:0]   a [4];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = gb(s, r, c);
      for (int r = 0; r < 4; r++)
        n[8*(4*r+c) +: 8] = inv ?
          (gm(8'h0E, a[r]) ^ gm(8'h0B, a[(r+1)%4]) ^ gm(8'h0D, a[(r+2)%4]) ^ gm(8'h09, a[(r+3)%4])) :
          (gm(8'h02, a[r]) ^ gm(8'h03, a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4]);
    end
    return n;
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic [127:0] k);
    logic [127:0] s;
    s = pt ^ rkey(k, 0);
    for (int rnd = 1; rnd < 10; rnd++) s = mix_c(shift_r(sub_b(s, 0), 0), 0) ^ rkey(k, rnd);
    return shift_r(sub_b(s, 0), 0) ^ rkey(k, 10);
  endfunction

  function automatic logic [127:0] model_dec(input logic [127:0] ct, input logic [127:0] k);
    logic [127:0] s;
    s = ct ^ rkey(k, 10);
    for (int rnd = 9; rnd >= 1; rnd--) s = mix_c(sub_b(shift_r(s, 1), 1) ^ rkey(k, rnd), 1);
    return sub_b(shift_r(s, 1), 1) ^ rkey(k, 0);
  endfunction

  // ---------------- cycle predictor and per-cycle compare ----------------
  logic [127:0] exp_out;
  logic [127:0] pend;
  logic         exp_done;
  logic         busy;
  int           rem;

  // An accepted start yields the model result 21 edges later; starts while busy are dropped
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_out  <= '0;
      exp_done <= 1'b0;
      busy     <= 1'b0;
      rem      <= 0;
      pend     <= '0;
    end else if (busy) begin
      if (rem == 1) begin
        exp_out  <= pend;
        exp_done <= 1'b1;
        busy     <= 1'b0;
      end
      rem <= rem - 1;
    end else if (bus.start) begin
      pend     <= model_dec(bus.data, bus.key);
      rem      <= 21;
      busy     <= 1'b1;
      exp_done <= 1'b0;
    end
  end

  // Outputs compared on every falling edge
  always @(negedge clk) begin
    check("cyc_out", bus.out, exp_out);
    check("cyc_done", 128'(bus.done), 128'(exp_done));
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!bus.done && n < 40) begin
      @(posedge clk);
      n++;
      #1;
    end
  endtask

  task automatic run_op(input logic [127:0] d, input logic [127:0] k,
                        input logic [127:0] exp, input string tag);
    int n;
    @(negedge clk);
    bus.data  = d;
    bus.key   = k;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    bus.key   = {$urandom(), $urandom(), $urandom(), $urandom()};
    wait_done(0, n);
    check({tag, "_lat"}, 128'(n), 128'd21);
    check({tag, "_out"}, bus.out, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0]   p;
    logic [7:0]   q;
    logic [7:0]   x;
    logic [127:0] kr;
    logic [127:0] pr;
    int           n;
    int           rises [3];
    int           nr;
    logic         prev;

    // S-box tables from the 3 / 1/3 generator walk
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ xt(p);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ r8(q, 1) ^ r8(q, 2) ^ r8(q, 3) ^ r8(q, 4);
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);

    bus.start = 1'b0;
    bus.data  = '0;
    bus.key   = '0;

    // Model pinned to published vectors
    check("model_fips_dec", model_dec(FIPS_CT, FIPS_K), FIPS_PT);
    check("model_fips_enc", model_enc(FIPS_PT, FIPS_K), FIPS_CT);
    check("model_zero_dec", model_dec(ZERO_CT, '0), '0);
    check("model_sbox", {120'h0, sb[8'h53]}, 128'hED);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out", bus.out, '0);
    check("rst_done", 128'(bus.done), 128'd0);
    rst = 1'b1;

    // FIPS vector and zero key
    run_op(FIPS_CT, FIPS_K, FIPS_PT, "fips");
    run_op(ZERO_CT, '0, '0, "zero");

    // Loopback with model-encrypted random pairs
    for (int i = 0; i < 200; i++) begin
      kr = {$urandom(), $urandom(), $urandom(), $urandom()};
      pr = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_op(model_enc(pr, kr), kr, pr, "loop");
    end

    // Start pulsed during ROUND is ignored
    @(negedge clk);
    bus.data  = FIPS_CT;
    bus.key   = FIPS_K;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (13) @(posedge clk);
    @(negedge clk);
    bus.data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    bus.key   = {$urandom(), $urandom(), $urandom(), $urandom()};
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(14, n);
    check("busy_lat", 128'(n), 128'd21);
    check("busy_out", bus.out, FIPS_PT);

    // Restart from DONE: done drops at E0, out holds until E21
    @(negedge clk);
    bus.data  = ZERO_CT;
    bus.key   = '0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    check("redo_done_drop", 128'(bus.done), 128'd0);
    check("redo_out_hold", bus.out, FIPS_PT);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(0, n);
    check("redo_lat", 128'(n), 128'd21);
    check("redo_out", bus.out, '0);

    // Leave a non-zero result, then abort an operation with reset at E15
    run_op(FIPS_CT, FIPS_K, FIPS_PT, "pre_rst");
    @(negedge clk);
    bus.data  = ZERO_CT;
    bus.key   = '0;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort_out", bus.out, '0);
    check("abort_done", 128'(bus.done), 128'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op(FIPS_CT, FIPS_K, FIPS_PT, "after_rst");

    // start held high: completions at E21, E43, E65
    @(negedge clk);
    bus.data  = FIPS_CT;
    bus.key   = FIPS_K;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    prev = bus.done;
    nr   = 0;
    for (int i = 0; i < 3; i++) rises[i] = 0;
    for (int e = 1; e <= 65; e++) begin
      @(posedge clk);
      #1;
      if (bus.done && !prev) begin
        if (nr < 3) rises[nr] = e;
        nr++;
        check("cont_out", bus.out, FIPS_PT);
      end
      prev = bus.done;
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("cont_count", 128'(nr), 128'd3);
    check("cont_e21", 128'(rises[0]), 128'd21);
    check("cont_e43", 128'(rises[1]), 128'd43);
    check("cont_e65", 128'(rises[2]), 128'd65);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_decrypt_iter.md
Name: aes_decrypt_iter

Overview:
Iterative AES-128 inverse cipher (FIPS-197 InvCipher) that recovers plaintext from ciphertext produced by the team's AES encryption core. It uses the same port shape, byte layout and start/done handshake as the encryptor, so the two cores can be swapped or looped back in benches. The core runs one round per clock. The round-10 key is derived on chip by a forward key expansion, and the earlier round keys are regenerated on the fly by the inverse key schedule.

Parameters:
NR, 10, number of AES rounds (AES-128 only; other values unsupported)

Ports:
clk    input   1    sole clock, rising edge
rst    input   1    asynchronous active-low reset
data   input   128  ciphertext; byte k = bits [8k+7:8k] = state row k/4, column k%4
key    input   128  cipher key (round-0 key), same byte layout as data
out    output  128  plaintext, same byte layout
start  input   1    begin operation; sampled on rising edge
done   output  1    out valid; level signal

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE; out=0, done=0, and all internal state, key and counter registers are 0. Reset during an operation aborts it with no output.
- FSM states: IDLE, KEXP, INIT, ROUND, FINAL, DONE.
- IDLE/DONE with start=1 at edge E0:
  - latch data into the state register and key into the key register;
  - counter = 1; done <= 0; go to KEXP.
- KEXP, edges E1..E10:
  - key <= forward KeyExpansion(key, rcon[counter]);
  - counter increments; after E10 the key register holds rk10.
  - rcon = 01,02,04,08,10,20,40,80,1B,36.
- INIT, edge E11:
  - state <= state ^ rk10;
  - key <= inverse expansion to rk9;
  - counter = 9.
- ROUND, edges E12..E20, round i = 9 down to 1:
  - state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_i);
  - key <= rk_(i-1) via inverse schedule, which uses rcon[i]:
    - w3' = w3^w2; w2' = w2^w1; w1' = w1^w0;
    - w0' = w0 ^ SubWord(RotWord(w3')) ^ rcon.
- FINAL, edge E21:
  - out <= InvSubBytes(InvShiftRows(state)) ^ rk0;
  - done <= 1; go to DONE.
- Latency: done rises 21 rising edges after the edge that sampled start. out changes only at E21 and holds until the next completion or reset.
- start is ignored while in KEXP/INIT/ROUND/FINAL. data and key may change freely after E0.
- start in DONE behaves as in IDLE: done falls at E0 and out keeps its old value until E21.
- start held high continuously causes back-to-back operations, one every 22 edges.
- Row/column mapping:
  - InvShiftRows rotates row r right by r columns.
  - InvMixColumns operates per column c on bytes {c, 4+c, 8+c, 12+c} with matrix 0E 0B 0D 09 (circulant).
  - All GF(2^8) multiplies use polynomial 0x11B.
- S-box implementation:
  - Sixteen inverse S-box lookups for the state.
  - Four forward S-box lookups shared between KEXP and the inverse schedule.
  - Both tables are instantiated from the team's sbox / inv_sbox library modules.
  - This block must not add a second copy of the forward table.
- Purely synchronous datapath; no combinational path from inputs to out or done.

Test Plan:
- FIPS vector in native layout:
  - key=128'h3C88A616_4F15D215_CFF7AE7E_09AB282B, data=128'h3297FB1D_0B850984_6A11DC25_19DC0239, start pulsed one cycle;
  - required: out=128'h34A28DA8_079830F6_37315A43_E0318832 with done rising exactly 21 edges after the start edge.
- Zero vector:
  - key=0, data=128'h2E593BD4_2BFA2C4B_344C8AE9_CA88EF66;
  - required: out=0 and done=1 at E21.
- Loopback against the encryptor:
  - 200 random key/plaintext pairs are encrypted by the existing AES core and fed to this block;
  - required: every out equals the original plaintext; latency is 21 every time.
- Busy handling:
  - while in ROUND, pulse start with different data/key;
  - required: no effect; the result matches the first request.
  - Then pulse start while in DONE; required: done drops on that edge, out holds, and the new result appears 21 edges later.
- Reset mid-operation:
  - assert rst=0 asynchronously between clock edges at E15, release, then restart;
  - required: out=0 and done=0 immediately on assertion; the next operation produces correct plaintext with normal latency.
- Continuous start:
  - hold start=1 for three operations using the FIPS vector;
  - required: done asserts at E21, E43 and E65 with correct out each time.
